// File: rtl/ext_stage.sv
// ext_stage: immediate extension unit with a small result FIFO.
// The extended value is computed when an immediate is accepted and stored,
// so the consumer always sees a registered result at the buffer head.
module ext_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       extop,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic [2:0] {
    EXT_ZERO      = 3'b000,
    EXT_SIGN      = 3'b001,
    EXT_UPPER     = 3'b010,
    EXT_BRANCH    = 3'b011,
    EXT_BYTE_SIGN = 3'b100,
    EXT_BYTE_ZERO = 3'b101,
    EXT_RSVD0     = 3'b110,
    EXT_RSVD1     = 3'b111
  } extop_e;

  extop_e            op;
  logic [OUT_W-1:0]  zext;
  logic [OUT_W-1:0]  sext;
  logic [OUT_W-1:0]  bzext;
  logic [OUT_W-1:0]  bsext;
  logic [OUT_W-1:0]  ext_data;
  logic              ext_err;

  logic [OUT_W:0]    mem [DEPTH];
  logic [OUT_W:0]    head;
  logic [CW-1:0]     count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  assign op = extop_e'(extop);

  // Pointers advance modulo DEPTH so non-power-of-two depths wrap correctly.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Build every extension candidate, then select by mode; reserved modes flag an error.
  always_comb begin
    zext     = OUT_W'(in_data);
    sext     = zext | (in_data[IN_W-1] ? ~OUT_W'({IN_W{1'b1}}) : '0);
    bzext    = OUT_W'(in_data[7:0]);
    bsext    = bzext | (in_data[7] ? ~OUT_W'(8'hFF) : '0);
    ext_data = '0;
    ext_err  = 1'b0;
    case (op)
      EXT_ZERO:      ext_data = zext;
      EXT_SIGN:      ext_data = sext;
      EXT_UPPER:     ext_data = zext << (OUT_W - IN_W);
      EXT_BRANCH:    ext_data = sext << 2;
      EXT_BYTE_SIGN: ext_data = bsext;
      EXT_BYTE_ZERO: ext_data = bzext;
      default: begin
        ext_data = '0;
        ext_err  = 1'b1;
      end
    endcase
  end

  // Handshakes depend only on registered occupancy, never on out_ready feeding in_ready.
  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage is left uncleared by reset; writes are suppressed when reset or flush discards the push.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) begin
      mem[wr_ptr] <= {ext_err, ext_data};
    end
  end

  // Occupancy and pointers: reset and flush both empty the buffer and override any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Head outputs read zero while empty so reset presents a clean, defined result.
  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head[OUT_W-1:0] : '0;
  assign out_err  = out_valid & head[OUT_W];

endmodule

// File: tb/tb_ext_stage.sv
// tb_ext_stage: scoreboard bench for ext_stage, driving a DEPTH=2 and a DEPTH=3
// instance with the same stimulus and comparing both against a queue model.
module tb_ext_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [2:0]  extop;
  logic [15:0] in_data;
  logic        out_ready;

  logic        in_ready2, out_valid2, out_err2;
  logic [31:0] out_data2;
  logic        in_ready3, out_valid3, out_err3;
  logic [31:0] out_data3;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  bit rst_seen = 0;

  logic [32:0] q2[$];
  logic [32:0] q3[$];
  logic [32:0] exp_val;
  bit acc2, pop2, acc3, pop3;

  ext_stage #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .extop(extop), .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_err(out_err2)
  );

  ext_stage #(.IN_W(16), .OUT_W(32), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
    .extop(extop), .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready),
    .out_data(out_data3), .out_err(out_err3)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference extension computed arithmetically from the mode definitions.
  function automatic logic [32:0] refExt(input logic [2:0] op, input logic [15:0] d);
    longint u  = longint'(d);
    longint s  = (d >= 16'h8000) ? u - 65536 : u;
    longint b  = u % 256;
    longint bs = (b >= 128) ? b - 256 : b;
    longint r  = 0;
    logic   e  = 1'b0;
    case (op)
      3'd0: r = u;
      3'd1: r = s;
      3'd2: r = u * 65536;
      3'd3: r = s * 4;
      3'd4: r = bs;
      3'd5: r = b;
      default: begin
        r = 0;
        e = 1'b1;
      end
    endcase
    return {e, r[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [15:0] d,
                               input logic r);
    in_valid  = v;
    extop     = op;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Model: accept/pop decisions from queue occupancy, expected results pushed on acceptance.
  always @(posedge clk) begin
    if (reset) begin
      q2.delete();
      q3.delete();
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      if (flush) begin
        q2.delete();
        q3.delete();
      end else begin
        exp_val = refExt(extop, in_data);
        acc2 = in_valid && (q2.size() < 2);
        pop2 = out_ready && (q2.size() > 0);
        acc3 = in_valid && (q3.size() < 3);
        pop3 = out_ready && (q3.size() > 0);
        if (pop2) void'(q2.pop_front());
        if (acc2) q2.push_back(exp_val);
        if (pop3) void'(q3.pop_front());
        if (acc3) q3.push_back(exp_val);
      end
    end
  end

  // Monitor: compare handshake flags and the head entry of each instance on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("out_valid2", 64'(out_valid2), 64'(q2.size() != 0));
      checkOutput("in_ready2", 64'(in_ready2), 64'(q2.size() < 2));
      if (q2.size() != 0) begin
        checkOutput("out_data2", 64'(out_data2), 64'(q2[0][31:0]));
        checkOutput("out_err2", 64'(out_err2), 64'(q2[0][32]));
      end
      checkOutput("out_valid3", 64'(out_valid3), 64'(q3.size() != 0));
      checkOutput("in_ready3", 64'(in_ready3), 64'(q3.size() < 3));
      if (q3.size() != 0) begin
        checkOutput("out_data3", 64'(out_data3), 64'(q3[0][31:0]));
        checkOutput("out_err3", 64'(out_err3), 64'(q3[0][32]));
      end
      if (rst_seen) begin
        checkOutput("rst_data2", 64'(out_data2), 64'd0);
        checkOutput("rst_err2", 64'(out_err2), 64'd0);
        checkOutput("rst_data3", 64'(out_data3), 64'd0);
        checkOutput("rst_err3", 64'(out_err3), 64'd0);
      end
    end
  end

  // Directed scenarios followed by a randomized run and a bounded drain.
  initial begin
    reset = 1'b1;
    flush = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0);
    mon_en = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready2", 64'(in_ready2), 64'd1);
    checkOutput("reset_out_valid2", 64'(out_valid2), 64'd0);

    // Four extension modes back to back with the consumer always ready.
    applyStimulus(1'b1, 3'd0, 16'h8001, 1'b1);
    @(negedge clk); checkOutput("zero_ext", 64'(out_data2), 64'h00008001);
    applyStimulus(1'b1, 3'd1, 16'h8001, 1'b1);
    @(negedge clk); checkOutput("sign_ext", 64'(out_data2), 64'hFFFF8001);
    applyStimulus(1'b1, 3'd2, 16'h8001, 1'b1);
    @(negedge clk); checkOutput("upper_ext", 64'(out_data2), 64'h80010000);
    applyStimulus(1'b1, 3'd3, 16'h8001, 1'b1);
    @(negedge clk); checkOutput("branch_ext", 64'(out_data3), 64'hFFFE0004);

    // Byte modes and a reserved mode.
    applyStimulus(1'b1, 3'd4, 16'h12F0, 1'b1);
    @(negedge clk); checkOutput("byte_sign", 64'(out_data2), 64'hFFFFFFF0);
    applyStimulus(1'b1, 3'd5, 16'h12F0, 1'b1);
    @(negedge clk); checkOutput("byte_zero", 64'(out_data2), 64'h000000F0);
    applyStimulus(1'b1, 3'd6, 16'h12F0, 1'b1);
    @(negedge clk);
    checkOutput("rsvd_data", 64'(out_data2), 64'h0);
    checkOutput("rsvd_err", 64'(out_err2), 64'd1);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);

    // Backpressure: DEPTH=2 fills after two pushes, DEPTH=3 takes a third and wraps.
    applyStimulus(1'b1, 3'd0, 16'h0011, 1'b0);
    applyStimulus(1'b1, 3'd1, 16'hFF00, 1'b0);
    @(negedge clk); checkOutput("full_in_ready2", 64'(in_ready2), 64'd0);
    applyStimulus(1'b1, 3'd2, 16'h0203, 1'b0);
    @(negedge clk);
    checkOutput("hold_data2", 64'(out_data2), 64'h00000011);
    checkOutput("full_in_ready3", 64'(in_ready3), 64'd0);
    applyStimulus(1'b1, 3'd5, 16'h7777, 1'b0);
    @(negedge clk); checkOutput("hold_data3", 64'(out_data3), 64'h00000011);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    @(negedge clk);
    checkOutput("order_b2", 64'(out_data2), 64'hFFFFFF00);
    checkOutput("order_b3", 64'(out_data3), 64'hFFFFFF00);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    @(negedge clk);
    checkOutput("no_c2", 64'(out_valid2), 64'd0);
    checkOutput("order_c3", 64'(out_data3), 64'h02030000);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);

    // Full buffer with push and pop offered together: pop only.
    applyStimulus(1'b1, 3'd0, 16'h1111, 1'b0);
    applyStimulus(1'b1, 3'd0, 16'h2222, 1'b0);
    applyStimulus(1'b1, 3'd0, 16'h3333, 1'b1);
    @(negedge clk);
    checkOutput("full_pop_ready2", 64'(in_ready2), 64'd1);
    checkOutput("full_pop_head2", 64'(out_data2), 64'h00002222);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);

    // Flush with a concurrent push discards everything.
    applyStimulus(1'b1, 3'd0, 16'h4444, 1'b0);
    applyStimulus(1'b1, 3'd0, 16'h5555, 1'b0);
    flush = 1'b1;
    applyStimulus(1'b1, 3'd0, 16'h6666, 1'b0);
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_valid2", 64'(out_valid2), 64'd0);
    checkOutput("flush_ready2", 64'(in_ready2), 64'd1);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);

    // Reset beats flush and push while the buffer holds an error entry.
    applyStimulus(1'b1, 3'd7, 16'h0F0F, 1'b0);
    applyStimulus(1'b1, 3'd1, 16'hABCD, 1'b0);
    reset = 1'b1;
    flush = 1'b1;
    applyStimulus(1'b1, 3'd0, 16'h9999, 1'b1);
    reset = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_valid2", 64'(out_valid2), 64'd0);
    checkOutput("rst_mid_data2", 64'(out_data2), 64'd0);
    checkOutput("rst_mid_err2", 64'(out_err2), 64'd0);
    checkOutput("rst_mid_ready2", 64'(in_ready2), 64'd1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      flush = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 149) == 0);
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                    $urandom_range(0, 2) != 0);
    end
    flush = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 20 && (q2.size() != 0 || q3.size() != 0); i++) begin
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    end
    checkOutput("drain_empty", 64'(q2.size() + q3.size()), 64'd0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_stage.md
EXT_STAGE -- requirements
Module: ext_stage

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate input width (legal: 8..OUT_W).
REQ-002 SHALL have parameter OUT_W, default 32, extended result width.
REQ-003 SHALL have parameter DEPTH, default 2, result buffer entries (legal: 1..16).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port flush  input  1  discard all buffered results.
REQ-007 SHALL have port in_valid  input  1  producer offers an immediate.
REQ-008 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-009 SHALL have port extop  input  3  extension mode, sampled with in_data.
REQ-010 SHALL have port in_data  input  IN_W  raw immediate.
REQ-011 SHALL have port out_valid  output  1  head result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes head result.
REQ-013 SHALL have port out_data  output  OUT_W  extended result at buffer head.
REQ-014 SHALL have port out_err  output  1  head result came from a reserved extop.

Function
REQ-015 SHALL compute the result at push time and store it; out_data is a buffered value, never a combinational function of current in_data.
REQ-016 extop 000 (zero) SHALL give in_data zero-extended to OUT_W.
REQ-017 extop 001 (sign) SHALL give in_data sign-extended from bit IN_W-1.
REQ-018 extop 010 (upper) SHALL give in_data in bits OUT_W-1..OUT_W-IN_W, zeros below.
REQ-019 extop 011 (branch) SHALL give sign-extended in_data shifted left 2, truncated to OUT_W.
REQ-020 extop 100 (byte sign) SHALL give in_data[7:0] sign-extended from bit 7.
REQ-021 extop 101 (byte zero) SHALL give in_data[7:0] zero-extended.
REQ-022 extop 110/111 (reserved) SHALL store data all-zero with out_err=1; all other modes store out_err=0.
REQ-023 Push SHALL occur when in_valid && in_ready at a rising edge; pop when out_valid && out_ready.
REQ-024 in_ready SHALL equal (count < DEPTH), from registered state only; no combinational path from out_ready to in_ready.
REQ-025 out_valid SHALL equal (count != 0); out_data/out_err SHALL reflect the oldest entry (FIFO order).
REQ-026 Latency SHALL be one cycle: push at edge N into empty buffer gives out_valid=1 and the result in the cycle after edge N.
REQ-027 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and preserve order.
REQ-028 While out_valid=1 and out_ready=0, out_data and out_err SHALL hold stable.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH, including non-power-of-two DEPTH.
REQ-030 When full, in_valid SHALL be ignored (no push, no overwrite), even if out_ready=1 that cycle.
REQ-031 Pop with count=0 SHALL have no effect (count never underflows).
REQ-032 flush=1 SHALL set count and both pointers to 0 at the next edge; any push or pop in that cycle SHALL be discarded.
REQ-033 count SHALL be clog2(DEPTH+1) bits wide and never exceed DEPTH.

Reset
REQ-034 reset=1 at a rising edge SHALL set count=0, pointers=0, out_valid=0, out_data=0, out_err=0, in_ready=1.
REQ-035 reset SHALL take priority over flush, push and pop in the same cycle, including mid-stream with buffered entries.
REQ-036 Buffer storage contents need not be cleared by reset; only control state and visible outputs are defined.

Verification
REQ-037 Defaults, out_ready=1: push in_data=16'h8001 with extop 000,001,010,011 on consecutive cycles -> out_data 32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004, each one cycle after push.
REQ-038 Byte modes: in_data=16'h12F0, extop 100 -> 32'hFFFFFFF0; extop 101 -> 32'h000000F0; extop 110 -> 32'h00000000 with out_err=1.
REQ-039 Backpressure DEPTH=2, out_ready=0: push A, B -> in_ready=0 after second push; third in_valid ignored; raise out_ready -> A then B in order, C never appears.
REQ-040 Full buffer with in_valid=1 and out_ready=1 same cycle -> one pop, no push; count 2->1, in_ready=1 next cycle.
REQ-041 Buffer holding 2 entries, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, count=0; pushed value never emitted.
REQ-042 Reset asserted while count=2 and flush=1 -> next cycle out_valid=0, out_data=0, out_err=0, in_ready=1; DEPTH=3 build repeats REQ-039 through pointer wrap.
